// File: rtl/reg_file_2r1w_if.sv
// reg_file_2r1w_if: decode-side request and operand-side response bundle of the register file.
interface reg_file_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              Read;
    logic              Write;
    logic              Clear;
    logic [ADDR_W-1:0] Ra;
    logic [ADDR_W-1:0] Rb;
    logic [ADDR_W-1:0] Rw;
    logic [DATA_W-1:0] Data;
    logic [DATA_W-1:0] OutA;
    logic [DATA_W-1:0] OutB;
    logic              Valid;
    logic              Busy;
    modport master (output Read, Write, Clear, Ra, Rb, Rw, Data, input OutA, OutB, Valid, Busy);
    modport slave  (input Read, Write, Clear, Ra, Rb, Rw, Data, output OutA, OutB, Valid, Busy);
endinterface

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two-read/one-write register file with bypass, zero register and sequential bulk clear.
module reg_file_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic            clk,
    input logic            rst,
    reg_file_2r1w_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [0:0] IDLE = 1'b0, CLEAR = 1'b1;
    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              idle, rd, wr;
    logic [DATA_W-1:0] va, vb;
    // Clear wins over Read/Write on the edge it is sampled in.
    always_comb begin
        idle = state == IDLE;
        rd = idle && bus.Read && !bus.Clear;
        wr = idle && bus.Write && !bus.Clear && !(ZERO_REG != 0 && bus.Rw == '0);
        va = (ZERO_REG != 0 && bus.Ra == '0) ? '0 :
             (BYPASS != 0 && bus.Write && bus.Rw == bus.Ra) ? bus.Data : mem[bus.Ra];
        vb = (ZERO_REG != 0 && bus.Rb == '0) ? '0 :
             (BYPASS != 0 && bus.Write && bus.Rw == bus.Rb) ? bus.Data : mem[bus.Rb];
    end
    assign bus.Busy = state == CLEAR;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bus.OutA <= '0;
            bus.OutB <= '0;
            bus.Valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            bus.Valid <= rd;
            if (rd) begin
                bus.OutA <= va;
                bus.OutB <= vb;
            end
            if (state == CLEAR) begin
                mem[cnt] <= '0;
                cnt <= cnt + 1'b1;
                state <= &cnt ? IDLE : CLEAR;
            end else begin
                if (bus.Clear) state <= CLEAR;
                if (wr) mem[bus.Rw] <= bus.Data;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed and randomized checks of reg_file_2r1w against a behavioural model.
module tb_reg_file_2r1w;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(4)) b0 ();
    reg_file_2r1w_if #(.DATA_W(8),  .ADDR_W(3)) b1 ();
    reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(4)) b2 ();

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    reg_file_2r1w #(.DATA_W(8),  .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    reg_file_2r1w #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    int checks = 0;
    int fails = 0;

    // Reference model of u0: register contents, clear cycles remaining, expected outputs.
    logic [31:0] mem [16];
    int          clr_left;
    logic [31:0] e_a, e_b;
    logic        e_v;

    task automatic idle_all();
        b0.Read = 0; b0.Write = 0; b0.Clear = 0; b0.Ra = 0; b0.Rb = 0; b0.Rw = 0; b0.Data = 0;
        b1.Read = 0; b1.Write = 0; b1.Clear = 0; b1.Ra = 0; b1.Rb = 0; b1.Rw = 0; b1.Data = 0;
        b2.Read = 0; b2.Write = 0; b2.Clear = 0; b2.Ra = 0; b2.Rb = 0; b2.Rw = 0; b2.Data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 0;
        clr_left = 0;
        e_a = 0;
        e_b = 0;
        e_v = 0;
    endtask

    function automatic logic [31:0] val(input logic [3:0] x, input logic w, input logic [3:0] rw, input logic [31:0] d);
        return (x == 0) ? 32'd0 : (w && rw == x) ? d : mem[x];
    endfunction

    task automatic step(input logic r, input logic w, input logic c, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] rw, input logic [31:0] d);
        b0.Read = r; b0.Write = w; b0.Clear = c; b0.Ra = ra; b0.Rb = rb; b0.Rw = rw; b0.Data = d;
        if (clr_left > 0) begin
            mem[16 - clr_left] = 0;
            clr_left--;
            e_v = 0;
        end else if (c) begin
            clr_left = 16;
            e_v = 0;
        end else begin
            if (r) begin
                e_a = val(ra, w, rw, d);
                e_b = val(rb, w, rw, d);
            end
            e_v = r;
            if (w && rw != 0) mem[rw] = d;
        end
        tick();
        b0.Read = 0; b0.Write = 0; b0.Clear = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 0;
        model_reset();
        step(0, 1, 0, 0, 0, 3, 32'hAA);
        step(1, 0, 0, 3, 3, 0, 0);
        checks++;
        if ({b0.OutA, b0.Valid} !== {32'hAA, 1'b1}) begin
            fails++;
            $display("FAIL reset_pre got %h/%b exp 000000aa/1", b0.OutA, b0.Valid);
        end
        @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({b0.OutA, b0.OutB, b0.Valid, b0.Busy} !== 66'd0) begin
            fails++;
            $display("FAIL reset_async got %h %h %b %b exp 0 0 0 0", b0.OutA, b0.OutB, b0.Valid, b0.Busy);
        end
        rst = 0;
        model_reset();
        step(1, 0, 0, 3, 5, 0, 0);
        checks++;
        if ({b0.OutA, b0.OutB, b0.Valid, b0.Busy} !== {32'd0, 32'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_read got %h %h %b %b exp 0 0 1 0", b0.OutA, b0.OutB, b0.Valid, b0.Busy);
        end
    endtask

    task automatic test_write_read();
        step(0, 1, 0, 0, 0, 1, 42);
        step(1, 0, 0, 1, 1, 0, 0);
        checks++;
        if ({b0.OutA, b0.OutB, b0.Valid} !== {32'd42, 32'd42, 1'b1}) begin
            fails++;
            $display("FAIL wr_rd got %0d %0d %b exp 42 42 1", b0.OutA, b0.OutB, b0.Valid);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({b0.OutA, b0.OutB, b0.Valid} !== {32'd42, 32'd42, 1'b0}) begin
            fails++;
            $display("FAIL wr_rd_hold got %0d %0d %b exp 42 42 0", b0.OutA, b0.OutB, b0.Valid);
        end
    endtask

    task automatic test_bypass_zero();
        step(0, 1, 0, 0, 0, 2, 7);
        step(1, 1, 0, 2, 2, 2, 99);
        checks++;
        if ({b0.OutA, b0.OutB} !== {32'd99, 32'd99}) begin
            fails++;
            $display("FAIL bypass got %0d %0d exp 99 99", b0.OutA, b0.OutB);
        end
        step(1, 1, 0, 2, 5, 5, 11);
        checks++;
        if ({b0.OutA, b0.OutB} !== {32'd99, 32'd11}) begin
            fails++;
            $display("FAIL bypass_indep got %0d %0d exp 99 11", b0.OutA, b0.OutB);
        end
        step(1, 1, 0, 0, 0, 0, 5);
        checks++;
        if ({b0.OutA, b0.OutB} !== 64'd0) begin
            fails++;
            $display("FAIL zero_bypass got %0d %0d exp 0 0", b0.OutA, b0.OutB);
        end
        step(1, 0, 0, 0, 2, 0, 0);
        checks++;
        if ({b0.OutA, b0.OutB} !== {32'd0, 32'd99}) begin
            fails++;
            $display("FAIL zero_reg got %0d %0d exp 0 99", b0.OutA, b0.OutB);
        end
    endtask

    task automatic test_no_bypass();
        b2.Write = 1; b2.Rw = 2; b2.Data = 7;
        tick();
        b2.Read = 1; b2.Ra = 2; b2.Data = 99;
        tick();
        checks++;
        if (b2.OutA !== 32'd7) begin
            fails++;
            $display("FAIL nobypass got %0d exp 7", b2.OutA);
        end
        b2.Write = 0;
        tick();
        checks++;
        if (b2.OutA !== 32'd99) begin
            fails++;
            $display("FAIL nobypass_after got %0d exp 99", b2.OutA);
        end
        b2.Read = 0; b2.Write = 1; b2.Rw = 0; b2.Data = 5;
        tick();
        b2.Write = 0; b2.Read = 1; b2.Ra = 0;
        tick();
        b2.Read = 0;
        checks++;
        if (b2.OutA !== 32'd5) begin
            fails++;
            $display("FAIL nozero got %0d exp 5", b2.OutA);
        end
    endtask

    task automatic test_clear();
        logic [31:0] held;
        int n;
        for (int i = 1; i < 16; i++) step(0, 1, 0, 0, 0, 4'(i), 32'(i));
        held = b0.OutA;
        step(0, 1, 1, 0, 0, 4, 77);
        n = b0.Busy ? 1 : 0;
        while (b0.Busy && n < 40) begin
            step(1, 1, 0, 4'($urandom), 4'($urandom), 4'($urandom), 32'hDEAD);
            if (b0.Busy) n++;
            checks++;
            if ({b0.Valid, b0.OutA} !== {1'b0, held}) begin
                fails++;
                $display("FAIL clear_quiet got %b %h exp 0 %h", b0.Valid, b0.OutA, held);
            end
        end
        checks++;
        if (n !== 16) begin
            fails++;
            $display("FAIL clear_busy_len got %0d exp 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 4'(i), 4'(15 - i), 0, 0);
            checks++;
            if ({b0.OutA, b0.OutB, b0.Valid} !== {32'd0, 32'd0, 1'b1}) begin
                fails++;
                $display("FAIL clear_zero[%0d] got %h %h %b exp 0 0 1", i, b0.OutA, b0.OutB, b0.Valid);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        step(0, 1, 0, 0, 0, 6, 32'h55);
        step(1, 0, 0, 6, 6, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({b0.OutA, b0.OutB, b0.Valid, b0.Busy} !== 66'd0) begin
            fails++;
            $display("FAIL midclear_rst got %h %h %b %b exp 0 0 0 0", b0.OutA, b0.OutB, b0.Valid, b0.Busy);
        end
        rst = 0;
        model_reset();
        step(0, 1, 0, 0, 0, 9, 32'h1234);
        step(1, 0, 0, 9, 9, 0, 0);
        checks++;
        if ({b0.OutA, b0.OutB, b0.Valid, b0.Busy} !== {32'h1234, 32'h1234, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL midclear_after got %h %h %b %b exp 1234 1234 1 0", b0.OutA, b0.OutB, b0.Valid, b0.Busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), $urandom_range(0, 24) == 0, 4'($urandom), 4'($urandom),
                 4'($urandom), $urandom);
            checks++;
            if ({b0.OutA, b0.OutB, b0.Valid, b0.Busy} !== {e_a, e_b, e_v, clr_left > 0}) begin
                fails++;
                $display("FAIL random[%0d] got %h %h %b %b exp %h %h %b %b", i, b0.OutA, b0.OutB,
                         b0.Valid, b0.Busy, e_a, e_b, e_v, clr_left > 0);
            end
        end
    endtask

    task automatic test_param_sweep();
        int n;
        for (int i = 1; i < 8; i++) begin
            b1.Write = 1; b1.Rw = 3'(i); b1.Data = 8'(i);
            tick();
        end
        b1.Write = 0; b1.Clear = 1;
        tick();
        b1.Clear = 0;
        n = b1.Busy ? 1 : 0;
        while (b1.Busy && n < 40) begin
            tick();
            if (b1.Busy) n++;
        end
        checks++;
        if (n !== 8) begin
            fails++;
            $display("FAIL sweep_busy_len got %0d exp 8", n);
        end
        for (int i = 0; i < 8; i++) begin
            b1.Read = 1; b1.Ra = 3'(i); b1.Rb = 3'(i);
            tick();
            checks++;
            if ({b1.OutA, b1.OutB} !== 16'd0) begin
                fails++;
                $display("FAIL sweep_zero[%0d] got %h %h exp 0 0", i, b1.OutA, b1.OutB);
            end
        end
        b1.Read = 0; b1.Write = 1; b1.Rw = 7; b1.Data = 8'hFF;
        tick();
        b1.Write = 0; b1.Read = 1; b1.Ra = 7; b1.Rb = 7;
        tick();
        b1.Read = 0;
        checks++;
        if ({b1.OutA, b1.OutB, b1.Valid} !== {8'hFF, 8'hFF, 1'b1}) begin
            fails++;
            $display("FAIL sweep_ff got %h %h %b exp ff ff 1", b1.OutA, b1.OutB, b1.Valid);
        end
    endtask

    initial begin
        idle_all();
        model_reset();
        test_reset();
        test_write_read();
        test_bypass_zero();
        test_no_bypass();
        test_clear();
        test_reset_mid_clear();
        test_random();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised two-read/one-write register file, the next generation of the `RegBase` register bank used by the datapath. It generalises data width and depth and adds a separate write address. It also adds optional write-to-read bypass, an optional hardwired-zero register 0, a registered read-valid strobe, and a sequential bulk-clear engine with a busy handshake. It sits between the decode stage (addresses, Read/Write strobes) and the ALU operand inputs (OutA/OutB).

## Interface
- `DATA_W`, 32: width of each register and of Data/OutA/OutB.
- `ADDR_W`, 4: address width; depth DEPTH = 2**ADDR_W.
- `ZERO_REG`, 1: 1 = register 0 always reads 0 and writes to it are discarded.
- `BYPASS`, 1: 1 = a read of the address being written in the same cycle returns the new Data.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `Read`  in  1  read request, sampled on edge.
- `Write`  in  1  write request, sampled on edge.
- `Ra`  in  ADDR_W  read address, port A.
- `Rb`  in  ADDR_W  read address, port B.
- `Rw`  in  ADDR_W  write address.
- `Data`  in  DATA_W  write data.
- `Clear`  in  1  start bulk clear, sampled on edge.
- `OutA`  out  DATA_W  registered read data, port A.
- `OutB`  out  DATA_W  registered read data, port B.
- `Valid`  out  1  OutA/OutB updated by a read accepted on the previous edge.
- `Busy`  out  1  clear engine active; Read/Write/Clear ignored.

## Operation
- Reset (async, any time including mid-clear): all DEPTH registers = 0; OutA = OutB = 0; Valid = 0; Busy = 0; FSM = IDLE; clear counter = 0.
- FSM states: IDLE, CLEAR.
- IDLE with Clear = 1:
  - Go to CLEAR.
  - Read and Write sampled on that edge are dropped; Clear has priority.
  - Valid = 0.
- CLEAR:
  - Each edge writes 0 to reg[cnt], then cnt increments.
  - On the edge that clears reg[DEPTH-1]: cnt wraps to 0, FSM returns to IDLE.
  - Busy = 1 exactly while FSM = CLEAR.
  - Read, Write and Clear are all ignored; OutA/OutB hold; Valid = 0.
- IDLE read (Read = 1): on the edge, OutA ← value(Ra), OutB ← value(Rb), Valid ← 1.
- IDLE, Read = 0: OutA/OutB hold; Valid ← 0.
- IDLE write (Write = 1): reg[Rw] ← Data.
  - If ZERO_REG = 1 and Rw = 0, the write is discarded.
- value(x), the value a read returns:
  - 0 if ZERO_REG = 1 and x = 0.
  - Otherwise Data, if BYPASS = 1 and Write = 1 and Rw = x in the same cycle.
  - Otherwise the stored reg[x], i.e. the pre-write value.
- Ra = Rb: both ports return the same value.
- Read and Write to different addresses in the same cycle: independent, no interaction.
- No arithmetic beyond the ADDR_W-bit wrapping clear counter.

## Timing
- Read latency: 1 edge. Read sampled at edge N gives OutA/OutB/Valid after edge N; Valid is a one-cycle pulse per accepted read.
- Write: stored at edge N.
  - A read sampled at edge N+1 sees the new value.
  - A read at edge N sees it only when BYPASS = 1.
- Clear sampled at edge N:
  - Busy = 1 from after edge N to after edge N+DEPTH, i.e. DEPTH cycles.
  - reg[k] is cleared at edge N+1+k.
  - The first accepted Read/Write is at edge N+DEPTH+1.
- rst asserted: outputs reach reset values without waiting for clk.
- rst deasserted: first active edge is the next rising clk.

## Test plan
- Reset then read: rst pulse; Read = 1, Ra = 3, Rb = 5 → after next edge OutA = 0, OutB = 0, Valid = 1.
- Write/read-back: write Rw = 1, Data = 42; next cycle Read, Ra = Rb = 1 → OutA = OutB = 42, Valid = 1; cycle after with Read = 0 → Valid = 0, outputs hold 42.
- Bypass and zero register:
  - reg[2] = 7. Same cycle: Write Rw = 2, Data = 99; Read Ra = 2 → OutA = 99 with BYPASS = 1, 7 with BYPASS = 0.
  - Write Rw = 0, Data = 5, then read Ra = 0 → OutA = 0 (ZERO_REG = 1).
- Bulk clear: fill regs 1..15 with their index; assert Clear at edge N together with Write Rw = 4, Data = 77.
  - Busy is high for exactly 16 cycles.
  - The Write and any Read during Busy have no effect; Valid stays 0.
  - Afterwards every register reads 0.
- Reset mid-clear: Clear, then rst asserted asynchronously 5 cycles later (between edges) → Busy = 0, OutA = OutB = 0, Valid = 0 immediately. A subsequent write/read of 0x1234 to reg[9] works normally.
- Parameter sweep: DATA_W = 8, ADDR_W = 3, then rerun the clear test → Busy high for 8 cycles; write 0xFF to reg[7] reads back 0xFF.
